reaction_game_core: RTL and testbench

Parametrised N-player reaction-game controller that succeeds the fixed two-player switch game. After a start request it runs a pseudo-random millisecond countdown and raises a GO indication. It punishes any player who flips early, awards the round to the first player to react after GO, and declares a winner at a configurable score. It sits between the board switch/button inputs and the seven-segment score formatter, and contains its own millisecond tick divider.

---
 rtl/reaction_game_core.sv | 255 +++++++++++++++++++++++++
 tb/tb_reaction_game_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_core.sv
// reaction_game_core
//   N-player reaction-game controller. After a start request it runs a
//   pseudo-random millisecond countdown and then raises go. A player who
//   flips early loses a point. The first player to react after go wins
//   the round. The game ends when a player reaches WIN_SCORE.
//
// Optional feature (compile-time macro REACT_TIMEOUT_EN):
//   defined   - the GO window closes after TIMEOUT_MS ticks. timeout pulses
//               and the FSM returns to ARM with no score change.
//   undefined - GO waits indefinitely and timeout is held at 0.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   start request, level sampled (synchronised internally)
//   sw         in   raw player switches (synchronised internally)
//   go         out  high throughout GO
//   state      out  FSM state encoding
//   score_flat out  player i score at [i*SCORE_W +: SCORE_W]
//   round_win  out  one-cycle pulse in AWARD
//   last_id    out  player of the last award or penalty
//   penalty    out  one-cycle pulse after an early flip
//   game_over  out  high in OVER
//   timeout    out  one-cycle pulse on GO-window expiry
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset, waiting for start
// ARM   | waiting for all switches low, then latch random delay
// COUNT | countdown running; any switch high is an early flip
// GO    | go raised; first switch high wins the round
// AWARD | one cycle; winner's score increments
// OVER  | winner reached WIN_SCORE; start clears scores
module reaction_game_core #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 5,
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RANGE_W      = 11,
  parameter int TIMEOUT_MS   = 3000,
  localparam int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         sw,
  output logic                           go,
  output logic [2:0]                     state,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score_flat,
  output logic                           round_win,
  output logic [PID_W-1:0]               last_id,
  output logic                           penalty,
  output logic                           game_over,
  output logic                           timeout
);

  localparam int DLY_MAX = MIN_DELAY_MS + (1 << RANGE_W) - 1;
  localparam int MS_MAX  = (DLY_MAX > TIMEOUT_MS) ? DLY_MAX : TIMEOUT_MS;
  localparam int MS_W    = $clog2(MS_MAX + 1);
  localparam int TK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_COUNT = 3'd2,
    S_GO    = 3'd3,
    S_AWARD = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t state_q, state_nxt;

  logic [NUM_PLAYERS-1:0] sw_m, sw_s;
  logic                   start_m, start_s;
  logic [15:0]            lfsr;
  logic [TK_W-1:0]        tick_cnt;
  logic                   tick;
  logic [MS_W-1:0]        ms_cnt;
  logic [MS_W-1:0]        delay;
  logic [SCORE_W-1:0]     score [NUM_PLAYERS];

  logic                   any_sw;
  logic [PID_W-1:0]       low_id;
  logic [SCORE_W-1:0]     cur_score, inc_val, dec_val;
  logic                   cnt_run, cnt_clr, load_delay, clr_scores;
  logic                   penalty_nxt, round_win_nxt, timeout_nxt;
  logic [PID_W-1:0]       last_id_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_m    <= '0;
      sw_s    <= '0;
      start_m <= 1'b0;
      start_s <= 1'b0;
    end else begin
      sw_m    <= sw;
      sw_s    <= sw_m;
      start_m <= start;
      start_s <= start_m;
    end
  end

  // Fibonacci LFSR, taps 16,14,13,11 (maximal length, never reaches zero).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign tick = (tick_cnt == '0);

`ifdef REACT_TIMEOUT_EN
  assign cnt_run = (state_q == S_COUNT) || (state_q == S_GO);
`else
  assign cnt_run = (state_q == S_COUNT);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= TK_W'(TICK_DIV - 1);
      ms_cnt   <= '0;
    end else if (cnt_clr) begin
      tick_cnt <= TK_W'(TICK_DIV - 1);
      ms_cnt   <= '0;
    end else if (cnt_run) begin
      if (tick) begin
        tick_cnt <= TK_W'(TICK_DIV - 1);
        ms_cnt   <= ms_cnt + MS_W'(1);
      end else begin
        tick_cnt <= tick_cnt - TK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           delay <= '0;
    else if (load_delay) delay <= MS_W'(MIN_DELAY_MS) + MS_W'(lfsr[RANGE_W-1:0]);
  end

  // Lowest-index active switch wins ties and takes early-flip penalties.
  always_comb begin
    any_sw = |sw_s;
    low_id = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (sw_s[i]) low_id = PID_W'(i);
    end
  end

  always_comb begin
    cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (PID_W'(i) == last_id) cur_score = score[i];
    end
    inc_val = (cur_score >= SCORE_W'(WIN_SCORE)) ? cur_score : cur_score + SCORE_W'(1);
    dec_val = (cur_score == '0) ? cur_score : cur_score - SCORE_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      penalty   <= 1'b0;
      round_win <= 1'b0;
      timeout   <= 1'b0;
      last_id   <= '0;
    end else begin
      state_q   <= state_nxt;
      penalty   <= penalty_nxt;
      round_win <= round_win_nxt;
      timeout   <= timeout_nxt;
      last_id   <= last_id_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    penalty_nxt   = 1'b0;
    round_win_nxt = 1'b0;
    timeout_nxt   = 1'b0;
    last_id_nxt   = last_id;
    load_delay    = 1'b0;
    cnt_clr       = 1'b0;
    clr_scores    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!any_sw) begin
          load_delay = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = S_COUNT;
        end
      end
      S_COUNT: begin
        // An early flip wins over a countdown expiring on the same cycle.
        if (any_sw) begin
          penalty_nxt = 1'b1;
          last_id_nxt = low_id;
          state_nxt   = S_ARM;
        end else if (ms_cnt == delay) begin
          cnt_clr   = 1'b1;
          state_nxt = S_GO;
        end
      end
      S_GO: begin
        if (any_sw) begin
          last_id_nxt   = low_id;
          round_win_nxt = 1'b1;
          state_nxt     = S_AWARD;
        end
`ifdef REACT_TIMEOUT_EN
        else if (ms_cnt == MS_W'(TIMEOUT_MS)) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_ARM;
        end
`endif
      end
      S_AWARD: begin
        if (inc_val == SCORE_W'(WIN_SCORE)) state_nxt = S_OVER;
        else                                state_nxt = S_ARM;
      end
      S_OVER: begin
        if (start_s) begin
          clr_scores = 1'b1;
          state_nxt  = S_ARM;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // round_win is high exactly in AWARD and penalty exactly in the cycle
  // after the early flip, so each drives a single score update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (clr_scores)                               score[i] <= '0;
        else if (round_win && PID_W'(i) == last_id)   score[i] <= inc_val;
        else if (penalty && PID_W'(i) == last_id)     score[i] <= dec_val;
      end
    end
  end

  always_comb begin
    score_flat = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) score_flat[i*SCORE_W +: SCORE_W] = score[i];
  end

  assign state     = state_q;
  assign go        = (state_q == S_GO);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_reaction_game_core.sv
// Directed bench for reaction_game_core with a 4-cycle tick and a 3..6 ms
// countdown. Inputs change and outputs are sampled on the falling edge.
module tb_reaction_game_core;

  localparam int NP = 2;
  localparam int SW = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_GO    = 3'd3;
  localparam logic [2:0] ST_AWARD = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NP-1:0]    sw;
  logic             go;
  logic [2:0]       state;
  logic [NP*SW-1:0] score_flat;
  logic             round_win;
  logic [0:0]       last_id;
  logic             penalty;
  logic             game_over;
  logic             timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reaction_game_core #(
    .NUM_PLAYERS(NP), .SCORE_W(SW), .WIN_SCORE(5), .TICK_DIV(4),
    .MIN_DELAY_MS(3), .RANGE_W(2), .TIMEOUT_MS(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sw(sw), .go(go),
    .state(state), .score_flat(score_flat), .round_win(round_win),
    .last_id(last_id), .penalty(penalty), .game_over(game_over),
    .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_go(input string tag);
    int n = 0;
    while (go !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(go), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // React with mask once go is high; leaves the bench on the cycle after AWARD.
  task automatic win_round(input logic [NP-1:0] mask, input logic [0:0] exp_id, input string tag);
    wait_go({tag, "_go"});
    sw = mask;
    repeat (3) @(negedge clk);
    check({tag, "_award"}, 32'(state), 32'(ST_AWARD));
    check({tag, "_rwin"}, 32'(round_win), 32'd1);
    check({tag, "_id"}, 32'(last_id), 32'(exp_id));
    @(negedge clk);
    sw = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] exp_pen [3];
    exp_pen[0] = 8'h11;
    exp_pen[1] = 8'h10;
    exp_pen[2] = 8'h10;

    reset = 1'b1;
    start = 1'b0;
    sw    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_go", 32'(go), 32'd0);
    check("rst_scores", 32'(score_flat), 32'd0);
    check("rst_pulses", {29'd0, round_win, penalty, timeout}, 32'd0);
    check("rst_id_over", {30'd0, last_id, game_over}, 32'd0);
    repeat (4) @(negedge clk);
    check("idle_hold", 32'(state), 32'(ST_IDLE));

    // Start, countdown, go latency = 4*delay+1 with delay in 3..6.
    pulse_start();
    wait_state(ST_ARM, "start_arm");
    wait_state(ST_COUNT, "arm_count");
    n = 0;
    while (go !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("go_lat_range", 32'(n >= 13 && n <= 25), 32'd1);
    check("go_state", 32'(state), 32'(ST_GO));

    // Player 1 wins; score updates the cycle after AWARD.
    win_round(2'b10, 1'b1, "p1_win");
    check("p1_win_state", 32'(state), 32'(ST_ARM));
    check("p1_win_score", 32'(score_flat), 32'h10);
    check("p1_win_rwin_low", 32'(round_win), 32'd0);

    // Tie goes to the lowest index.
    win_round(2'b11, 1'b0, "tie");
    check("tie_score", 32'(score_flat), 32'h11);

    win_round(2'b01, 1'b0, "p0_win");
    check("p0_win_score", 32'(score_flat), 32'h12);

    // Early flips by player 0: 2 -> 1 -> 0 -> 0.
    for (int k = 0; k < 3; k++) begin
      wait_state(ST_COUNT, "pen_count");
      repeat (3) @(negedge clk);
      sw = 2'b01;
      repeat (3) @(negedge clk);
      check("pen_state", 32'(state), 32'(ST_ARM));
      check("pen_pulse", 32'(penalty), 32'd1);
      check("pen_id", 32'(last_id), 32'd0);
      @(negedge clk);
      check("pen_score", 32'(score_flat), 32'(exp_pen[k]));
      check("pen_pulse_low", 32'(penalty), 32'd0);
      sw = '0;
    end

    // Player 1 takes four more rounds to reach 5.
    for (int k = 2; k <= 5; k++) begin
      win_round(2'b10, 1'b1, "run");
      check("run_score", 32'(score_flat), 32'(k << 4));
    end
    check("over_state", 32'(state), 32'(ST_OVER));
    check("over_flag", 32'(game_over), 32'd1);
    repeat (5) @(negedge clk);
    check("over_hold", 32'(score_flat), 32'h50);

    pulse_start();
    wait_state(ST_ARM, "restart_arm");
    check("restart_scores", 32'(score_flat), 32'd0);
    check("restart_over_low", 32'(game_over), 32'd0);

    wait_go("to_go");
`ifdef REACT_TIMEOUT_EN
    n = 0;
    while (state !== ST_ARM && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 32'(n), 32'd9);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_scores", 32'(score_flat), 32'd0);
    @(negedge clk);
    check("to_pulse_low", 32'(timeout), 32'd0);
`else
    repeat (40) @(negedge clk);
    check("no_to_go", 32'(go), 32'd1);
    check("no_to_state", 32'(state), 32'(ST_GO));
    check("no_to_pulse", 32'(timeout), 32'd0);
`endif

    // Mid-operation reset clears everything at once.
    win_round(2'b01, 1'b0, "pre_rst");
    check("pre_rst_score", 32'(score_flat), 32'h01);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(state), 32'(ST_IDLE));
    check("mid_rst_scores", 32'(score_flat), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
